// File: rtl/sub_bytes_seq_pkg.sv
// Shared constants for the sequential SubBytes engine: byte width and FSM encodings.
package sub_bytes_seq_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUB  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A one-byte state still needs a one-bit index register.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/sub_bytes_seq_sbox.sv
// Combinational FIPS-197 forward S-box, 8-bit in, 8-bit out, no internal registers.
module sub_bytes_seq_sbox
    import sub_bytes_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] data_i,
    output logic [BYTE_W-1:0] data_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign data_o = SBOX[data_i];

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential SubBytes engine: one byte per clock through a single shared S-box,
// valid/ready on both sides, back-to-back accept from DONE without a bubble.
module sub_bytes_seq
    import sub_bytes_seq_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_data,
    output logic                     busy
);

    localparam int               IDX_W    = idx_width(NBYTES);
    localparam int               DATA_W   = BYTE_W * NBYTES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [BYTE_W-1:0] sbox_in, sbox_out;

    // Ready is a function of state and out_ready only, so upstream may wait on it.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SUB);
    assign out_data  = out_q;

    always_comb begin
        sbox_in = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx_q == IDX_W'(k)) sbox_in = buf_q[k*BYTE_W +: BYTE_W];
        end
    end

    sub_bytes_seq_sbox u_sbox (
        .data_i (sbox_in),
        .data_o (sbox_out)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no branch infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    buf_d   = in_data;
                    idx_d   = '0;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (idx_q == IDX_W'(k)) out_d[k*BYTE_W +: BYTE_W] = sbox_out;
                end
                if (idx_q == LAST_IDX) state_d = ST_DONE;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        buf_d   = in_data;
                        idx_d   = '0;
                        state_d = ST_SUB;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments; the data registers are reset too
        // because downstream observes out_data=0 right after reset.
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq at NBYTES = 2, 16 and 1.
module tb_sub_bytes_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [15:0]  in_data2, out_data2;
    logic         in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [127:0] in_data16, out_data16;
    logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [7:0]   in_data1, out_data1;

    sub_bytes_seq #(.NBYTES(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .busy(busy2));
    sub_bytes_seq #(.NBYTES(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16), .busy(busy16));
    sub_bytes_seq #(.NBYTES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .busy(busy1));

    int checks = 0;
    int errors = 0;
    int pops1  = 0;

    logic [15:0]  q2[$];
    logic [127:0] q16[$];
    logic [7:0]   q1[$];
    logic [7:0]   ref_sbox [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference S-box derived from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        for (int x = 1; x < 256; x++) begin
            if (gmul(v, 8'(x)) == 8'h01) inv = 8'(x);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    task automatic wait_out(input int which, output int lat);
        logic v;
        lat = 0;
        v = (which == 2) ? out_valid2 : (which == 16) ? out_valid16 : out_valid1;
        while (!v && lat < 100) begin
            tick();
            lat++;
            v = (which == 2) ? out_valid2 : (which == 16) ? out_valid16 : out_valid1;
        end
    endtask

    // Monitors: pop the expected word whenever a DONE handshake is about to complete.
    always @(negedge clk) begin
        if (!rst && out_valid2 && out_ready2) begin
            if (q2.size() == 0) check("u2_unexpected_word", {112'd0, out_data2}, 128'hx);
            else                check("u2_word", {112'd0, out_data2}, {112'd0, q2.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid16 && out_ready16) begin
            if (q16.size() == 0) check("u16_unexpected_word", out_data16, 128'hx);
            else                 check("u16_word", out_data16, q16.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            pops1++;
            if (q1.size() == 0) check("u1_unexpected_byte", {120'd0, out_data1}, 128'hx);
            else                check("u1_byte", {120'd0, out_data1}, {120'd0, q1.pop_front()});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int busy_cnt;
        int guard;

        for (int v = 0; v < 256; v++) ref_sbox[v] = sbox_model(8'(v));

        rst = 1'b1;
        in_valid2 = 1'b0;  out_ready2 = 1'b0;  in_data2 = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; in_data16 = '0;
        in_valid1 = 1'b0;  out_ready1 = 1'b0;  in_data1 = '0;
        repeat (2) tick();
        check("rst_in_ready", in_ready2, 1);
        check("rst_out_valid", out_valid2, 0);
        check("rst_busy", busy2, 0);
        check("rst_out_data", out_data2, 0);
        rst = 1'b0;

        // 1: single word, latency 2
        out_ready2 = 1'b1; in_valid2 = 1'b1; in_data2 = 16'h0053; q2.push_back(16'h63ed);
        tick();
        in_valid2 = 1'b0; in_data2 = 16'hdead;
        wait_out(2, lat);
        check("t1_latency", lat, 2);
        tick();
        check("t1_back_idle_ready", in_ready2, 1);

        // 2: back-to-back with in_valid held
        in_valid2 = 1'b1; in_data2 = 16'hffaa; q2.push_back(16'h16ac);
        tick();
        in_data2 = 16'h1234; q2.push_back(16'hc918);
        wait_out(2, lat);
        check("t2_latency_a", lat, 2);
        check("t2_in_ready_in_done", in_ready2, 1);
        tick();
        check("t2_no_bubble", busy2, 1);
        in_valid2 = 1'b0;
        wait_out(2, lat);
        check("t2_latency_b", lat, 2);
        tick();

        // 3: backpressure for 5 cycles in DONE
        out_ready2 = 1'b0; in_valid2 = 1'b1; in_data2 = 16'h0001; q2.push_back(16'h637c);
        tick();
        in_data2 = 16'h0010;
        wait_out(2, lat);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", out_valid2, 1);
            check("t3_hold_data", out_data2, 16'h637c);
            check("t3_hold_in_ready", in_ready2, 0);
            tick();
        end
        q2.push_back(16'h63ca);
        out_ready2 = 1'b1;
        #1;
        check("t3_release_in_ready", in_ready2, 1);
        tick();
        check("t3_accept_same_edge", busy2, 1);
        in_valid2 = 1'b0;
        wait_out(2, lat);
        check("t3_latency", lat, 2);
        tick();

        // 4: reset after byte 0 discards the word
        in_valid2 = 1'b1; in_data2 = 16'habcd;
        tick();
        in_valid2 = 1'b0;
        tick();
        check("t4_mid_sub", busy2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_out_valid", out_valid2, 0);
        check("t4_out_data", out_data2, 0);
        check("t4_in_ready", in_ready2, 1);
        check("t4_busy", busy2, 0);
        in_valid2 = 1'b1; in_data2 = 16'h0053; q2.push_back(16'h63ed);
        tick();
        in_valid2 = 1'b0;
        wait_out(2, lat);
        check("t4_latency", lat, 2);
        tick();

        // 5: NBYTES=16, all-zero state
        out_ready16 = 1'b1; in_valid16 = 1'b1; in_data16 = '0; q16.push_back({16{8'h63}});
        tick();
        in_valid16 = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!out_valid16 && lat < 100) begin
            if (busy16) busy_cnt++;
            tick();
            lat++;
        end
        check("t5_latency", lat, 16);
        check("t5_busy_cycles", busy_cnt, 16);
        check("t5_busy_done", busy16, 0);
        tick();

        // 6: NBYTES=1 exhaustive sweep against the reference model
        out_ready1 = 1'b1; in_valid1 = 1'b1;
        for (int v = 0; v < 256; v++) begin
            in_data1 = 8'(v);
            q1.push_back(ref_sbox[v]);
            guard = 0;
            while (!in_ready1 && guard < 10) begin
                tick();
                guard++;
            end
            tick();
        end
        in_valid1 = 1'b0;
        guard = 0;
        while (q1.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("t6_byte_count", pops1, 256);

        repeat (3) tick();
        check("end_q2_empty", q2.size(), 0);
        check("end_q16_empty", q16.size(), 0);
        check("end_q1_empty", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
